// File: rtl/conv1d_dilated_stream_pkg.sv
// Shared types and helpers for the dilated/strided streaming 1D convolution.
// Also holds the round-half-up / saturate function used on the accumulator.
package conv1d_pkg;

    typedef enum logic [1:0] {ST_ACCEPT, ST_MAC, ST_HOLD} state_t;

    localparam int MAX_ACC_W = 128;
    typedef logic signed [MAX_ACC_W-1:0] wide_t;

    function automatic int span_of(input int kernel, input int dilation);
        return dilation * (kernel - 1) + 1;
    endfunction

    function automatic int acc_w_of(input int data_w, input int kernel);
        return 2 * data_w + $clog2(kernel) + 1;
    endfunction

    function automatic int idx_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round half up by adding 2^(frac_bits-1), shift arithmetically, then clamp to data_w signed range.
    function automatic wide_t sat_round(input wide_t acc, input int frac_bits, input int data_w);
        wide_t one;
        wide_t v;
        wide_t hi;
        wide_t lo;
        one = wide_t'(1);
        v   = acc;
        if (frac_bits > 0) begin
            v = v + (one <<< (frac_bits - 1));
        end
        v  = v >>> frac_bits;
        hi = (one <<< (data_w - 1)) - one;
        lo = -(one <<< (data_w - 1));
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv1d_dilated_stream_if.sv
// Sample-in / result-out valid-ready stream bundle for conv1d_dilated_stream.
interface conv1d_dilated_stream_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv1d_mac_unit.sv
// Signed multiply-accumulate with synchronous clear/enable and a rounded, saturated view of the sum.
module conv1d_mac_unit
    import conv1d_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 35,
    parameter int FRAC_BITS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Accumulator is idle outside the MAC phase, so this stays stable while a result is held.
    assign result = DATA_W'(sat_round({{(MAX_ACC_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}, FRAC_BITS, DATA_W));

endmodule

// File: rtl/conv1d_dilated_stream.sv
// Streaming dilated/strided 1D convolution: window shift register, weight file, ACCEPT/MAC/HOLD
// control; one tap per cycle through conv1d_mac_unit.
module conv1d_dilated_stream
    import conv1d_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int KERNEL    = 3,
    parameter int DILATION  = 2,
    parameter int STRIDE    = 1,
    parameter int FRAC_BITS = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_wr_en,
    input  logic [idx_w_of(KERNEL)-1:0]   w_addr,
    input  logic signed [DATA_W-1:0]      w_data,
    conv1d_dilated_stream_if.slave        sif,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int SPAN  = span_of(KERNEL, DILATION);
    localparam int ACC_W = acc_w_of(DATA_W, KERNEL);
    localparam int AW    = idx_w_of(KERNEL);
    localparam int FW    = $clog2(SPAN + 1);
    localparam int SW    = idx_w_of(STRIDE);

    state_t                   state_q, state_d;
    logic [FW-1:0]            fill_q, fill_d;
    logic [SW-1:0]            stride_q, stride_d;
    logic [AW-1:0]            tap_q, tap_d;
    logic                     out_last_q, out_last_d;
    logic                     frame_done_q, frame_done_d;
    logic signed [DATA_W-1:0] window_q [SPAN];
    logic signed [DATA_W-1:0] window_d [SPAN];
    logic signed [DATA_W-1:0] window_shift [SPAN];
    logic signed [DATA_W-1:0] tap_x [KERNEL];
    logic signed [DATA_W-1:0] w_q [KERNEL];
    logic signed [DATA_W-1:0] w_d [KERNEL];

    logic                     accept;
    logic                     full_now;
    logic                     mac_clear;
    logic                     mac_en;
    logic signed [DATA_W-1:0] mac_result;

    // Index 0 is the oldest sample; new samples enter at SPAN-1.
    genvar gi;
    generate
        for (gi = 0; gi < SPAN; gi++) begin : g_shift
            if (gi == SPAN - 1) begin : g_head
                assign window_shift[gi] = sif.in_data;
            end else begin : g_body
                assign window_shift[gi] = window_q[gi+1];
            end
        end
        for (gi = 0; gi < KERNEL; gi++) begin : g_tap
            assign tap_x[gi] = window_q[gi*DILATION];
        end
    endgenerate

    assign busy     = (fill_q != '0) || (state_q != ST_ACCEPT);
    assign accept   = sif.in_valid && (state_q == ST_ACCEPT);
    assign full_now = (fill_q == FW'(SPAN - 1)) || (fill_q == FW'(SPAN));

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        stride_d     = stride_q;
        tap_d        = tap_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        window_d     = window_q;
        w_d          = w_q;
        mac_clear    = 1'b0;
        mac_en       = 1'b0;

        if (w_wr_en && !busy && (int'(w_addr) < KERNEL)) begin
            w_d[w_addr] = w_data;
        end

        case (state_q)
            ST_ACCEPT: begin
                if (accept) begin
                    window_d = window_shift;
                    fill_d   = (fill_q == FW'(SPAN)) ? fill_q : fill_q + FW'(1);
                    if (full_now) begin
                        stride_d = (stride_q == SW'(STRIDE - 1)) ? '0 : stride_q + SW'(1);
                    end
                    if (full_now && (stride_q == '0)) begin
                        state_d    = ST_MAC;
                        mac_clear  = 1'b1;
                        tap_d      = '0;
                        out_last_d = sif.in_last;
                    end else if (sif.in_last) begin
                        frame_done_d = 1'b1;
                        fill_d       = '0;
                        stride_d     = '0;
                        for (int i = 0; i < SPAN; i++) window_d[i] = '0;
                    end
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (tap_q == AW'(KERNEL - 1)) begin
                    state_d = ST_HOLD;
                end else begin
                    tap_d = tap_q + AW'(1);
                end
            end
            ST_HOLD: begin
                if (sif.out_ready) begin
                    state_d    = ST_ACCEPT;
                    out_last_d = 1'b0;
                    // A held last-result closes the frame only once it has been taken.
                    if (out_last_q) begin
                        frame_done_d = 1'b1;
                        fill_d       = '0;
                        stride_d     = '0;
                        for (int i = 0; i < SPAN; i++) window_d[i] = '0;
                    end
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCEPT;
            fill_q       <= '0;
            stride_q     <= '0;
            tap_q        <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < SPAN; i++) window_q[i] <= '0;
            for (int i = 0; i < KERNEL; i++) w_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            stride_q     <= stride_d;
            tap_q        <= tap_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            window_q     <= window_d;
            w_q          <= w_d;
        end
    end

    conv1d_mac_unit #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .FRAC_BITS(FRAC_BITS)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (w_q[tap_q]),
        .b     (tap_x[tap_q]),
        .result(mac_result)
    );

    assign sif.in_ready  = (state_q == ST_ACCEPT);
    assign sif.out_valid = (state_q == ST_HOLD);
    assign sif.out_data  = mac_result;
    assign sif.out_last  = out_last_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_conv1d_dilated_stream.sv
// Scoreboard bench: stimulus pushes hand-computed results, per-instance monitors pop and compare.
// Instance a runs STRIDE=1, instance b runs STRIDE=2; sel steers the shared drivers.
module tb_conv1d_dilated_stream;

    typedef struct packed {
        logic signed [15:0] d;
        logic               l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               sel       = 1'b0;
    logic               drv_valid = 1'b0;
    logic               drv_last  = 1'b0;
    logic               drv_ready = 1'b1;
    logic signed [15:0] drv_data  = '0;
    logic               w_en      = 1'b0;
    logic [1:0]         w_addr    = '0;
    logic signed [15:0] w_data    = '0;

    logic w_en_a, w_en_b, fd_a, fd_b, busy_a, busy_b, cur_ready;

    int   compared   = 0;
    int   mismatched = 0;
    int   fd_cnt_a   = 0;
    int   fd_cnt_b   = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;

    conv1d_dilated_stream_if #(.DATA_W(16)) if_a ();
    conv1d_dilated_stream_if #(.DATA_W(16)) if_b ();

    assign if_a.in_valid  = drv_valid & ~sel;
    assign if_b.in_valid  = drv_valid & sel;
    assign if_a.in_data   = drv_data;
    assign if_b.in_data   = drv_data;
    assign if_a.in_last   = drv_last;
    assign if_b.in_last   = drv_last;
    assign if_a.out_ready = drv_ready & ~sel;
    assign if_b.out_ready = drv_ready & sel;
    assign w_en_a         = w_en & ~sel;
    assign w_en_b         = w_en & sel;
    assign cur_ready      = sel ? if_b.in_ready : if_a.in_ready;

    conv1d_dilated_stream #(
        .DATA_W(16), .KERNEL(3), .DILATION(2), .STRIDE(1), .FRAC_BITS(0)
    ) dut_a (
        .clk(clk), .rst(rst), .w_wr_en(w_en_a), .w_addr(w_addr), .w_data(w_data),
        .sif(if_a), .frame_done(fd_a), .busy(busy_a)
    );

    conv1d_dilated_stream #(
        .DATA_W(16), .KERNEL(3), .DILATION(2), .STRIDE(2), .FRAC_BITS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .w_wr_en(w_en_b), .w_addr(w_addr), .w_data(w_data),
        .sif(if_b), .frame_done(fd_b), .busy(busy_b)
    );

    // Monitors: one compare per output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (fd_a) fd_cnt_a++;
            if (if_a.out_valid && if_a.out_ready) begin
                compared++;
                if (exp_a.size() == 0) begin
                    mismatched++;
                    $display("FAIL out_a unexpected: got data=%0d last=%0d, required no output",
                             if_a.out_data, if_a.out_last);
                end else begin
                    ea = exp_a.pop_front();
                    if (if_a.out_data !== ea.d || if_a.out_last !== ea.l) begin
                        mismatched++;
                        $display("FAIL out_a: got data=%0d last=%0d, required data=%0d last=%0d",
                                 if_a.out_data, if_a.out_last, ea.d, ea.l);
                    end else begin
                        $display("out_a data=%0d last=%0d ok", if_a.out_data, if_a.out_last);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fd_b) fd_cnt_b++;
            if (if_b.out_valid && if_b.out_ready) begin
                compared++;
                if (exp_b.size() == 0) begin
                    mismatched++;
                    $display("FAIL out_b unexpected: got data=%0d last=%0d, required no output",
                             if_b.out_data, if_b.out_last);
                end else begin
                    eb = exp_b.pop_front();
                    if (if_b.out_data !== eb.d || if_b.out_last !== eb.l) begin
                        mismatched++;
                        $display("FAIL out_b: got data=%0d last=%0d, required data=%0d last=%0d",
                                 if_b.out_data, if_b.out_last, eb.d, eb.l);
                    end else begin
                        $display("out_b data=%0d last=%0d ok", if_b.out_data, if_b.out_last);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input bit to_b, input int d, input bit l);
        exp_t e;
        e.d = 16'(d);
        e.l = l;
        if (to_b) exp_b.push_back(e);
        else      exp_a.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int addr, input int d);
        w_addr = 2'(addr);
        w_data = 16'(d);
        w_en   = 1'b1;
        tick();
        w_en   = 1'b0;
    endtask

    task automatic load_w(input int w0, input int w1, input int w2);
        write_w(0, w0);
        write_w(1, w1);
        write_w(2, w2);
    endtask

    task automatic send(input int d, input bit l);
        int  n;
        bit  taken;
        n        = 0;
        drv_data = 16'(d);
        drv_last = l;
        drv_valid = 1'b1;
        do begin
            taken = cur_ready;
            tick();
            n++;
        end while (!taken && n < 200);
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        if (!taken) begin
            compared++;
            mismatched++;
            $display("FAIL send timeout: got no accept of %0d, required accept within 200 cycles", d);
        end
    endtask

    task automatic send_range(input int lo, input int hi, input bit last_at_end);
        for (int v = lo; v <= hi; v++) send(v, last_at_end && (v == hi));
    endtask

    task automatic send_const(input int v, input int n);
        for (int i = 0; i < n; i++) send(v, i == n - 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("drain pending outputs", exp_a.size() + exp_b.size(), 0);
    endtask

    int f0;
    int n;

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset in_ready",   if_a.in_ready,  1);
        check("reset out_valid",  if_a.out_valid, 0);
        check("reset out_data",   if_a.out_data,  0);
        check("reset out_last",   if_a.out_last,  0);
        check("reset frame_done", fd_a,           0);
        check("reset busy",       busy_a,         0);

        // Stride 1: four outputs, last flag only on the final one.
        sel = 1'b0;
        load_w(1, 2, 3);
        push_exp(0, 22, 0); push_exp(0, 28, 0); push_exp(0, 34, 0); push_exp(0, 40, 1);
        f0 = fd_cnt_a;
        send_range(1, 8, 1);
        drain();
        check("s1 frame_done count", fd_cnt_a - f0, 1);
        check("s1 busy after frame", busy_a, 0);

        // Stride 2: last sample does not arm, so frame_done follows its accept directly.
        sel = 1'b1;
        load_w(1, 2, 3);
        push_exp(1, 22, 0); push_exp(1, 34, 0);
        f0 = fd_cnt_b;
        send_range(1, 7, 0);
        send(8, 1);
        check("s2 frame_done pulse", fd_b, 1);
        tick();
        check("s2 frame_done width", fd_b, 0);
        drain();
        check("s2 frame_done count", fd_cnt_b - f0, 1);
        sel = 1'b0;

        // Saturation at both rails.
        load_w(32767, 32767, 32767);
        push_exp(0, 32767, 1);
        send_const(32767, 5);
        drain();
        push_exp(0, -32768, 1);
        send_const(-32768, 5);
        drain();

        // Backpressure in HOLD: result stable, no samples taken.
        load_w(1, 2, 3);
        drv_ready = 1'b0;
        push_exp(0, 22, 1);
        send_range(1, 5, 1);
        n = 0;
        while (!if_a.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("hold reached", if_a.out_valid, 1);
        drv_data  = 16'sd99;
        drv_last  = 1'b0;
        drv_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("hold out_valid", if_a.out_valid, 1);
            check("hold out_data",  if_a.out_data,  22);
            check("hold in_ready",  if_a.in_ready,  0);
            tick();
        end
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        drain();

        // Mid-frame weight write is dropped; after the frame it lands.
        push_exp(0, 22, 0); push_exp(0, 28, 0); push_exp(0, 34, 0); push_exp(0, 40, 1);
        send_range(1, 3, 0);
        check("midframe busy", busy_a, 1);
        write_w(0, 9);
        send_range(4, 8, 1);
        drain();
        check("post-frame busy", busy_a, 0);
        write_w(0, 9);
        push_exp(0, 30, 1);
        send_range(1, 5, 1);
        drain();

        // Reset during MAC clears everything including weights.
        send_range(1, 5, 1);
        check("mac in_ready", if_a.in_ready, 0);
        check("mac busy",     busy_a,        1);
        rst = 1'b1;
        tick();
        check("rst-in-mac in_ready",   if_a.in_ready,  1);
        check("rst-in-mac out_valid",  if_a.out_valid, 0);
        check("rst-in-mac out_data",   if_a.out_data,  0);
        check("rst-in-mac out_last",   if_a.out_last,  0);
        check("rst-in-mac frame_done", fd_a,           0);
        check("rst-in-mac busy",       busy_a,         0);
        rst = 1'b0;
        tick();
        push_exp(0, 0, 1);
        send_range(1, 5, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
